// File: rtl/sdram_wide_port.sv
// sdram_wide_port: splits 128-bit requests into eight 16-bit Avalon beats.
// Option: SDRAM_SKIP_EMPTY_BEAT_EN drops write beats with no byte enables.
module sdram_wide_port #(
  parameter int BEATS = 8,
  parameter int AW    = 22,
  parameter int SAW   = 25
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [AW-1:0]  ar_addr,
  input  logic [15:0]    ar_be,
  input  logic           ar_read,
  input  logic           ar_write,
  input  logic [127:0]   ar_wrdata,
  output logic           ar_ac,
  output logic [127:0]   ar_rddata,
  output logic [SAW-1:0] av_address,
  output logic           av_read,
  output logic           av_write,
  output logic [15:0]    av_writedata,
  output logic [1:0]     av_byteenable,
  input  logic           av_waitrequest,
  input  logic [15:0]    av_readdata,
  input  logic           av_readdatavalid
);

  typedef enum logic [2:0] {
    IDLE, WR, RD_ISSUE, RD_WAIT, ACK
  } state_t;

  localparam logic [2:0] LAST = 3'(BEATS - 1);

  state_t       state, state_nx;
  logic [AW-1:0] addr_q;
  logic [15:0]  be_q;
  logic [127:0] wrdata_q;
  logic [127:0] asm_q, asm_nx;
  logic [2:0]   issue_cnt, ret_cnt;
  logic         accept, last_ret;
  logic [2:0]   wr_first, wr_next;
  logic         wr_none, wr_done;

`ifdef SDRAM_SKIP_EMPTY_BEAT_EN
  // {none_found, index} of the first beat at or after 'from' with enables
  function automatic logic [3:0] find_beat(
    input logic [15:0] be,
    input logic [3:0]  from
  );
    logic [3:0] r;
    r = 4'd8;
    for (int i = BEATS - 1; i >= 0; i--)
      if (i >= int'(from) && be[2*i +: 2] != 2'b00)
        r = 4'(i);
    return r;
  endfunction

  assign {wr_none, wr_first} = find_beat(ar_be, 4'd0);
  assign {wr_done, wr_next}  = find_beat(be_q, {1'b0, issue_cnt} + 4'd1);
`else
  assign wr_none  = 1'b0;
  assign wr_first = 3'd0;
  assign wr_done  = issue_cnt == LAST;
  assign wr_next  = issue_cnt + 3'd1;
`endif

  assign accept   = (state == WR || state == RD_ISSUE) && !av_waitrequest;
  assign last_ret = state == RD_WAIT && av_readdatavalid && ret_cnt == LAST;

  always_comb begin
    asm_nx = asm_q;
    if (av_readdatavalid)
      asm_nx[16*ret_cnt +: 16] = av_readdata;
  end

  always_comb begin
    state_nx      = state;
    ar_ac         = 1'b0;
    av_address    = '0;
    av_read       = 1'b0;
    av_write      = 1'b0;
    av_writedata  = '0;
    av_byteenable = 2'b11;
    unique case (state)
      IDLE: begin
        if (ar_write)
          state_nx = wr_none ? ACK : WR;
        else if (ar_read)
          state_nx = RD_ISSUE;
      end
      WR: begin
        av_write      = 1'b1;
        av_address    = {addr_q, issue_cnt};
        av_writedata  = wrdata_q[16*issue_cnt +: 16];
        av_byteenable = be_q[2*issue_cnt +: 2];
        if (accept && wr_done)
          state_nx = ACK;
      end
      RD_ISSUE: begin
        av_read    = 1'b1;
        av_address = {addr_q, issue_cnt};
        if (accept && issue_cnt == LAST)
          state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (last_ret)
          state_nx = ACK;
      end
      ACK: begin
        ar_ac    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wrdata_q  <= '0;
      asm_q     <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      ar_rddata <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (ar_write || ar_read) begin
            addr_q    <= ar_addr;
            be_q      <= ar_be;
            wrdata_q  <= ar_wrdata;
            issue_cnt <= ar_write ? wr_first : 3'd0;
            ret_cnt   <= '0;
          end
        end
        WR: begin
          if (accept)
            issue_cnt <= wr_next;
        end
        RD_ISSUE, RD_WAIT: begin
          if (state == RD_ISSUE && accept)
            issue_cnt <= issue_cnt + 3'd1;
          // returns may overlap issue; slot follows return order
          if (av_readdatavalid) begin
            asm_q   <= asm_nx;
            ret_cnt <= ret_cnt + 3'd1;
          end
          if (last_ret)
            ar_rddata <= asm_nx;
        end
        default: begin
          issue_cnt <= '0;
          ret_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
